// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer sharing one registered-read data memory port.
// Port 0 has priority; port 1 wins a contested cycle after MAX_WAIT consecutive losses.
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [3:0]  cmd0,
   input  logic [3:0]  cmd1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        busy,
   output logic [3:0]  mem_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   typedef enum logic [1:0] { IDLE, ACCESS, RDATA } state_t;

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt, wait_d;
   logic        win_q, win_d;
   logic        short_q;
   logic        grant, pick1;
   logic [3:0]  sel_cmd;
   logic [31:0] sel_addr, sel_wdata;
   logic        gnt0_d, gnt1_d, done0_d, done1_d, cap0, cap1;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_cnt;
      win_d     = win_q;
      grant     = 1'b0;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      cap0      = 1'b0;
      cap1      = 1'b0;
      pick1     = req1 && (!req0 || (wait_cnt == WAIT_MAX));
      sel_cmd   = pick1 ? cmd1   : cmd0;
      sel_addr  = pick1 ? addr1  : addr0;
      sel_wdata = pick1 ? wdata1 : wdata0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               grant   = 1'b1;
               state_d = ACCESS;
               win_d   = pick1;
               gnt0_d  = !pick1;
               gnt1_d  = pick1;
               if (pick1)
                  wait_d = '0;
               else if (req1 && (wait_cnt < WAIT_MAX))
                  wait_d = wait_cnt + 4'd1;
            end
         end
         ACCESS: begin
            // Stores and no-ops finish here; loads wait for the memory output register.
            if (short_q) begin
               state_d = IDLE;
               done0_d = !win_q;
               done1_d = win_q;
            end else begin
               state_d = RDATA;
            end
         end
         RDATA: begin
            state_d = IDLE;
            done0_d = !win_q;
            done1_d = win_q;
            cap0    = !win_q;
            cap1    = win_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wait_cnt <= '0;
         win_q    <= 1'b0;
         short_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_cnt <= wait_d;
         win_q    <= win_d;
         if (grant)
            short_q <= sel_cmd[2] || (sel_cmd[1:0] == 2'b00);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         busy      <= 1'b0;
         mem_en    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         gnt0   <= gnt0_d;
         gnt1   <= gnt1_d;
         done0  <= done0_d;
         done1  <= done1_d;
         busy   <= (state_d != IDLE);
         // A size-00 command is granted but never enables the memory.
         mem_en <= (grant && (sel_cmd[1:0] != 2'b00)) ? sel_cmd : 4'b0000;
         if (grant) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
         if (cap0)
            rdata0 <= mem_rdata;
         if (cap1)
            rdata1 <= mem_rdata;
      end
   end
endmodule
